pcss_link_rx: RTL

Receive-side link endpoint between the PCSS chip's send port and host-side AXI-stream logic. It accepts 16-bit parity-protected flits from the chip (send_data_out/valid/par into ready/err) and checks parity. It packs four flits into one 64-bit word, buffers words in a FIFO and presents them on an AXI-stream master. An all-ones word marks end of packet and is flagged with tlast.

---
 rtl/pcss_link_rx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pcss_link_rx.sv
// pcss_link_rx: receive endpoint for the PCSS chip send port.
// Accepts 16-bit parity-protected flits and checks their parity. Packs four
// flits MSB-first into one 64-bit word and buffers the words in a small FIFO.
// The FIFO drains onto an AXI-stream master. An all-ones word is flagged with
// tlast.
//
// Handshake rules, on both sides: a transfer happens on the rising clock edge
// where valid and ready are both high. valid never waits for ready. ready is
// driven only from registers, so neither link_valid nor M_AXIS_tready reaches
// an output combinationally.
module pcss_link_rx #(
    parameter int                    LINK_W     = 16,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH      = 8,
    parameter logic [DATA_WIDTH-1:0] EOP_WORD   = {DATA_WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LINK_W-1:0]         link_data_in,
    input  logic                      link_valid,
    input  logic                      link_par,
    output logic                      link_ready,
    output logic                      link_err,
    output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
    output logic                      M_AXIS_tvalid,
    output logic                      M_AXIS_tlast,
    output logic [DATA_WIDTH/8-1:0]   M_AXIS_tkeep,
    input  logic                      M_AXIS_tready,
    output logic [15:0]               err_cnt,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    // Assembly state. The last flit goes straight into the FIFO, so only the
    // upper three flit slots need to be held.
    logic [1:0]                   flit_cnt;
    logic [DATA_WIDTH-1:LINK_W]   asm_q;

    // FIFO storage, pointers and the word shown while the FIFO is empty
    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic                         last_mem [DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [DATA_WIDTH-1:0]        hold_data;
    logic                         hold_last;

    logic                         accept;
    logic                         par_ok;
    logic                         push;
    logic                         pop;
    logic [DATA_WIDTH-1:0]        full_word;

    // Only the fourth flit needs FIFO room. The first three are always taken.
    assign link_ready = (flit_cnt != 2'd3) || (fifo_level < FULL_LVL);
    assign accept     = link_valid && link_ready;
    assign par_ok     = (link_par == ^link_data_in);
    assign push       = accept && par_ok && (flit_cnt == 2'd3);
    assign pop        = M_AXIS_tvalid && M_AXIS_tready;
    assign full_word  = {asm_q, link_data_in};

    assign M_AXIS_tvalid = (fifo_level != '0);
    assign M_AXIS_tdata  = M_AXIS_tvalid ? mem[rd_ptr] : hold_data;
    assign M_AXIS_tlast  = M_AXIS_tvalid ? last_mem[rd_ptr] : hold_last;
    assign M_AXIS_tkeep  = '1;

    // Flit assembly. A parity error throws away the partial word and restarts
    // the count at flit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt <= 2'd0;
            asm_q    <= '0;
        end else if (accept) begin
            if (!par_ok || flit_cnt == 2'd3) begin
                flit_cnt <= 2'd0;
                asm_q    <= '0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (flit_cnt == 2'(k)) begin
                        asm_q[(3-k)*LINK_W +: LINK_W] <= link_data_in;
                    end
                end
                flit_cnt <= flit_cnt + 2'd1;
            end
        end
    end

    // Parity error pulse back to the chip, plus a saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_err <= 1'b0;
            err_cnt  <= 16'd0;
        end else begin
            link_err <= accept && !par_ok;
            if (accept && !par_ok && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    // Word storage. An entry is only read while the FIFO holds it, so the
    // array needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]      <= full_word;
            last_mem[wr_ptr] <= (full_word == EOP_WORD);
        end
    end

    // FIFO pointers and level. The popped word is kept so tdata holds its last value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                hold_data <= mem[rd_ptr];
                hold_last <= last_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule
